count_sampler: RTL and testbench

//   Downstream consumer of the 3-bit ripple counter outputs (Count0..Count2).

---
 rtl/count_pkg.sv | 18 +
 rtl/sync_chain.sv | 29 ++
 rtl/count_sampler.sv | 132 +++++++++++++
 tb/tb_count_sampler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared constants and helpers for the ripple-counter sampler.
//   COUNT_WIDTH  default number of counter bits sampled
//   step_delta() (cur - prev) mod 2^width, used to classify accepted changes
package count_pkg;

  localparam int unsigned COUNT_WIDTH = 3;

  // Modular difference between two counts of the given width (width <= 32).
  function automatic logic [31:0] step_delta(input logic [31:0] cur,
                                             input logic [31:0] prev,
                                             input int unsigned width);
    logic [31:0] mask;
    if (width >= 32) mask = '1;
    else             mask = (32'd1 << width) - 32'd1;
    return (cur - prev) & mask;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: single-bit multi-flop synchroniser for an asynchronous input.
//   clock   in  system clock, rising edge
//   resetn  in  asynchronous active-low reset (chain clears to 0)
//   d       in  asynchronous input bit
//   q       out synchronised bit (last stage)
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/count_sampler.sv
// count_sampler: synchronises asynchronous ripple-counter outputs, rejects
// transient carry-propagation codes, and publishes each settled count as an
// event on a one-deep valid/ready interface.
//   clock         in  system clock, rising edge
//   resetn        in  asynchronous active-low reset
//   count_in      in  raw ripple counter bits {Count2,Count1,Count0}
//   err_clr       in  clears skip_err and ovf_err (a same-cycle set wins)
//   evt_ready     in  consumer accepts the pending event
//   evt_valid     out event pending
//   evt_count     out settled count carried by the event
//   evt_wrap      out event is a MAX->0 step
//   stable_count  out last accepted count
//   skip_err      out sticky: accepted change was not +1 mod 2^WIDTH
//   ovf_err       out sticky: an event was dropped while one was pending
module count_sampler
  import count_pkg::*;
#(
  parameter int unsigned WIDTH         = COUNT_WIDTH,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_count,
  output logic             evt_wrap,
  output logic [WIDTH-1:0] stable_count,
  output logic             skip_err,
  output logic             ovf_err
);

  localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync_out;

  for (genvar b = 0; b < WIDTH; b++) begin : g_sync
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clock  (clock),
      .resetn (resetn),
      .d      (count_in[b]),
      .q      (sync_out[b])
    );
  end

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [SCW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [WIDTH-1:0] stable_count_q, stable_count_d;
  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_count_q, evt_count_d;
  logic             evt_wrap_q, evt_wrap_d;
  logic             skip_err_q, skip_err_d;
  logic             ovf_err_q, ovf_err_d;

  logic accept;
  logic is_step;

  assign accept  = (stab_cnt_q == STAB_MAX) && (cand_q != stable_count_q);
  assign is_step = (step_delta(32'(cand_q), 32'(stable_count_q), WIDTH) == 32'd1);

  always_comb begin
    cand_d         = cand_q;
    stab_cnt_d     = stab_cnt_q;
    stable_count_d = stable_count_q;
    evt_valid_d    = evt_valid_q;
    evt_count_d    = evt_count_q;
    evt_wrap_d     = evt_wrap_q;
    skip_err_d     = skip_err_q;
    ovf_err_d      = ovf_err_q;

    // Stability filter: restart the run length whenever the sample changes.
    if (sync_out != cand_q) begin
      cand_d     = sync_out;
      stab_cnt_d = SCW'(1);
    end else if (stab_cnt_q < STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + SCW'(1);
    end

    // Clear first so that a set below in the same cycle takes priority.
    if (err_clr) begin
      skip_err_d = 1'b0;
      ovf_err_d  = 1'b0;
    end

    if (accept) begin
      stable_count_d = cand_q;
      if (!is_step) skip_err_d = 1'b1;
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_count_d = cand_q;
        evt_wrap_d  = is_step && (cand_q == '0);
      end else begin
        ovf_err_d = 1'b1;
      end
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cand_q         <= '0;
      stab_cnt_q     <= STAB_MAX;  // reset value 0 counts as already settled
      stable_count_q <= '0;
      evt_valid_q    <= 1'b0;
      evt_count_q    <= '0;
      evt_wrap_q     <= 1'b0;
      skip_err_q     <= 1'b0;
      ovf_err_q      <= 1'b0;
    end else begin
      cand_q         <= cand_d;
      stab_cnt_q     <= stab_cnt_d;
      stable_count_q <= stable_count_d;
      evt_valid_q    <= evt_valid_d;
      evt_count_q    <= evt_count_d;
      evt_wrap_q     <= evt_wrap_d;
      skip_err_q     <= skip_err_d;
      ovf_err_q      <= ovf_err_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_count    = evt_count_q;
  assign evt_wrap     = evt_wrap_q;
  assign stable_count = stable_count_q;
  assign skip_err     = skip_err_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_count_sampler.sv
// Testbench for count_sampler: drives settled and rippling counter codes and
// checks delivered events against a queue of expected events.
module tb_count_sampler;

  localparam int unsigned W = 3;

  logic         clock = 1'b0;
  logic         resetn;
  logic [W-1:0] count_in;
  logic         err_clr;
  logic         evt_ready;
  logic         evt_valid;
  logic [W-1:0] evt_count;
  logic         evt_wrap;
  logic [W-1:0] stable_count;
  logic         skip_err;
  logic         ovf_err;

  always #5 clock = ~clock;

  count_sampler #(.WIDTH(W), .SYNC_STAGES(2), .STABLE_CYCLES(2)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .count_in     (count_in),
    .err_clr      (err_clr),
    .evt_ready    (evt_ready),
    .evt_valid    (evt_valid),
    .evt_count    (evt_count),
    .evt_wrap     (evt_wrap),
    .stable_count (stable_count),
    .skip_err     (skip_err),
    .ovf_err      (ovf_err)
  );

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrap;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Scoreboard: every handshake must match the oldest expected event.
  always @(negedge clock) begin
    if (resetn === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected: got count=%0d wrap=%0b, required no event",
                 evt_count, evt_wrap);
      end else begin
        mon_e = exp_q.pop_front();
        if ({evt_count, evt_wrap} !== mon_e) begin
          bad++;
          $display("FAIL evt_data: got count=%0d wrap=%0b, required count=%0d wrap=%0b",
                   evt_count, evt_wrap, mon_e.cnt, mon_e.wrap);
        end
      end
    end
  end

  // Present a settled code and give it time to be accepted and consumed.
  task automatic step(input logic [W-1:0] v, input bit push, input logic wrap);
    evt_t e;
    @(negedge clock);
    count_in = v;
    if (push) begin
      e.cnt  = v;
      e.wrap = wrap;
      exp_q.push_back(e);
    end
    repeat (7) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int vcount;
    resetn    = 1'b0;
    count_in  = '0;
    err_clr   = 1'b0;
    evt_ready = 1'b1;
    #22;
    total++;
    if ({evt_valid, evt_count, evt_wrap, stable_count, skip_err, ovf_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {evt_valid, evt_count, evt_wrap, stable_count, skip_err, ovf_err});
    end
    @(negedge clock);
    resetn = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (evt_valid === 1'b1) vcount++;
    end
    total++;
    if (vcount !== 0) begin
      bad++;
      $display("FAIL reset_no_event: got %0d valid cycles, required 0", vcount);
    end
    total++;
    if (stable_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_stable: got %0d, required 0", stable_count);
    end
  endtask

  task automatic test_latency();
    evt_t e;
    @(negedge clock);
    count_in = 3'd1;
    e.cnt  = 3'd1;
    e.wrap = 1'b0;
    exp_q.push_back(e);
    repeat (4) @(posedge clock);
    #1;
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_edge4: got valid=%b, required 0", evt_valid);
    end
    @(posedge clock);
    #1;
    total++;
    if ({evt_valid, evt_count, evt_wrap} !== {1'b1, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL latency_edge5: got valid=%b count=%0d wrap=%b, required 1 1 0",
               evt_valid, evt_count, evt_wrap);
    end
    @(posedge clock);
    #1;
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_pulse: got valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_ripple();
    evt_t e;
    step(3'd2, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    @(negedge clock) count_in = 3'd2;
    @(negedge clock) count_in = 3'd0;
    @(negedge clock) count_in = 3'd4;
    e.cnt  = 3'd4;
    e.wrap = 1'b0;
    exp_q.push_back(e);
    repeat (8) @(posedge clock);
    #1;
    total++;
    if (skip_err !== 1'b0) begin
      bad++;
      $display("FAIL ripple_skip: got %b, required 0", skip_err);
    end
    total++;
    if (stable_count !== 3'd4) begin
      bad++;
      $display("FAIL ripple_stable: got %0d, required 4", stable_count);
    end
  endtask

  task automatic test_wrap_skip();
    step(3'd5, 1'b1, 1'b0);
    step(3'd6, 1'b1, 1'b0);
    step(3'd7, 1'b1, 1'b0);
    step(3'd0, 1'b1, 1'b1);
    total++;
    if ({stable_count, skip_err} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL wrap_state: got stable=%0d skip=%b, required 0 0", stable_count, skip_err);
    end
    step(3'd3, 1'b1, 1'b0);
    total++;
    if (skip_err !== 1'b1) begin
      bad++;
      $display("FAIL skip_set: got %b, required 1", skip_err);
    end
    @(negedge clock) err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    total++;
    if (skip_err !== 1'b0) begin
      bad++;
      $display("FAIL skip_clear: got %b, required 0", skip_err);
    end
  endtask

  task automatic test_back_to_back();
    step(3'd0, 1'b1, 1'b0);
    @(negedge clock) err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr   = 1'b0;
    evt_ready = 1'b0;
    step(3'd1, 1'b1, 1'b0);
    total++;
    if ({evt_valid, evt_count, ovf_err} !== {1'b1, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL hold_first: got valid=%b count=%0d ovf=%b, required 1 1 0",
               evt_valid, evt_count, ovf_err);
    end
    step(3'd2, 1'b0, 1'b0);
    total++;
    if (evt_count !== 3'd1) begin
      bad++;
      $display("FAIL hold_count: got %0d, required 1", evt_count);
    end
    total++;
    if (ovf_err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b, required 1", ovf_err);
    end
    total++;
    if (stable_count !== 3'd2) begin
      bad++;
      $display("FAIL ovf_stable: got %0d, required 2", stable_count);
    end
    evt_ready = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL ready_drop: got valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_mid_reset();
    int vcount;
    evt_ready = 1'b0;
    step(3'd3, 1'b1, 1'b0);
    total++;
    if (evt_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pending: got valid=%b, required 1", evt_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({evt_valid, evt_count, evt_wrap} !== '0) begin
      bad++;
      $display("FAIL midrst_event: got valid=%b count=%0d wrap=%b, required 0 0 0",
               evt_valid, evt_count, evt_wrap);
    end
    total++;
    if ({stable_count, skip_err, ovf_err} !== '0) begin
      bad++;
      $display("FAIL midrst_state: got stable=%0d skip=%b ovf=%b, required 0 0 0",
               stable_count, skip_err, ovf_err);
    end
    count_in = '0;
    exp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    evt_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (evt_valid === 1'b1) vcount++;
    end
    total++;
    if (vcount !== 0) begin
      bad++;
      $display("FAIL midrst_spurious: got %0d valid cycles, required 0", vcount);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ripple();
    test_wrap_skip();
    test_back_to_back();
    test_mid_reset();
    repeat (4) @(posedge clock);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL events_missing: got %0d undelivered, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
